// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - MIPS instruction fetch stage with IF/ID pipeline register
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_pc4,
  output logic [31:0] id_instr,
  output logic        id_valid
);

  // FETCH: request outstanding at fa.
  // HOLD:  word captured in hbuf while ID was stalled; no request.
  // DROP:  request at a stale address must complete, but its word is discarded.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] fa;
  logic [31:0] hbuf;
  logic [31:0] fa_plus4;
  logic        redir;

  // A stall means branch operands are not ready, so the redirect is not yet trusted.
  assign redir    = flush & ~stall;
  assign fa_plus4 = fa + 32'd4;

  // The request is a pure decode of the state register; address is the in-flight address.
  assign imem_req  = (state != HOLD);
  assign imem_addr = fa;

  // Fetch sequencing, redirect handling and the IF/ID register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      fa       <= RESET_PC;
      hbuf     <= 32'd0;
      id_pc4   <= 32'd0;
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            if (redir) begin
              // Returned word is on the wrong path; restart at the target.
              id_instr <= NOP_INSTR;
              id_valid <= 1'b0;
              pc       <= redirect_pc;
              fa       <= redirect_pc;
            end else if (stall) begin
              // ID cannot accept; park the word until the stall clears.
              hbuf  <= imem_rdata;
              state <= HOLD;
            end else begin
              id_pc4   <= fa_plus4;
              id_instr <= imem_rdata;
              id_valid <= 1'b1;
              pc       <= fa_plus4;
              fa       <= fa_plus4;
            end
          end else begin
            if (redir) begin
              // Address must stay stable until ack, so only pc takes the target.
              id_instr <= NOP_INSTR;
              id_valid <= 1'b0;
              pc       <= redirect_pc;
              state    <= DROP;
            end else if (!stall) begin
              id_instr <= NOP_INSTR;
              id_valid <= 1'b0;
            end
          end
        end

        HOLD: begin
          if (!stall) begin
            if (redir) begin
              id_instr <= NOP_INSTR;
              id_valid <= 1'b0;
              pc       <= redirect_pc;
              fa       <= redirect_pc;
            end else begin
              id_pc4   <= fa_plus4;
              id_instr <= hbuf;
              id_valid <= 1'b1;
              pc       <= fa_plus4;
              fa       <= fa_plus4;
            end
            state <= FETCH;
          end
        end

        DROP: begin
          if (!stall) begin
            id_instr <= NOP_INSTR;
            id_valid <= 1'b0;
          end
          // Later redirects overwrite the pending target.
          if (redir) begin
            pc <= redirect_pc;
          end
          if (imem_ack) begin
            fa    <= redir ? redirect_pc : pc;
            state <= FETCH;
          end
        end

        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - scoreboard testbench for if_id_stage
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] id_pc4;
  logic [31:0] id_instr;
  logic        id_valid;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  if_id_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .id_pc4     (id_pc4),
    .id_instr   (id_instr),
    .id_valid   (id_valid)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
  endfunction

  assign imem_rdata = imem_ack ? word(imem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc4, input logic [31:0] addr);
    exp_q.push_back({pc4, word(addr)});
  endtask

  task automatic go(input logic a, input logic s, input logic f, input logic [31:0] t);
    imem_ack    = a;
    stall       = s;
    flush       = f;
    redirect_pc = t;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Monitor: an instruction in ID leaves on a non-stalled cycle, so compare it exactly then.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst === 1'b0 && id_valid === 1'b1 && stall === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL id_unexpected actual pc4=%h instr=%h required=none", id_pc4, id_instr);
      end else begin
        e = exp_q.pop_front();
        chk("id_pc4", id_pc4, e[63:32]);
        chk("id_instr", id_instr, e[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    go(0, 0, 0, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'hBFC0_0000);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_pc4", id_pc4, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Straight-line fetch
    go(1, 0, 0, 32'h0);
    chk("t1_addr0", imem_addr, 32'hBFC0_0000);
    push(32'hBFC0_0004, 32'hBFC0_0000);
    adv();
    go(1, 0, 0, 32'h0);
    chk("t1_addr1", imem_addr, 32'hBFC0_0004);
    chk("t1_valid", {31'd0, id_valid}, 32'd1);
    push(32'hBFC0_0008, 32'hBFC0_0004);
    adv();

    // Stall on ack of BFC00008
    go(1, 1, 0, 32'h0);
    chk("t2_addr", imem_addr, 32'hBFC0_0008);
    push(32'hBFC0_000C, 32'hBFC0_0008);
    adv();
    for (int i = 0; i < 2; i++) begin
      go(0, 1, 0, 32'h0);
      chk("t2_req_hold", {31'd0, imem_req}, 32'd0);
      chk("t2_pc4_frozen", id_pc4, 32'hBFC0_0008);
      chk("t2_valid_frozen", {31'd0, id_valid}, 32'd1);
      adv();
    end
    go(0, 0, 0, 32'h0);
    chk("t2_req_release", {31'd0, imem_req}, 32'd0);
    adv();
    go(1, 0, 0, 32'h0);
    chk("t2_resume_addr", imem_addr, 32'hBFC0_000C);
    chk("t2_held_instr", id_instr, word(32'hBFC0_0008));
    chk("t2_held_pc4", id_pc4, 32'hBFC0_000C);
    push(32'hBFC0_0010, 32'hBFC0_000C);
    adv();

    // Flush with ack in the same cycle
    go(1, 0, 1, 32'h8000_0100);
    chk("t3_addr", imem_addr, 32'hBFC0_0010);
    adv();
    go(1, 0, 0, 32'h0);
    chk("t3_bubble_valid", {31'd0, id_valid}, 32'd0);
    chk("t3_bubble_instr", id_instr, 32'h0);
    chk("t3_target_addr", imem_addr, 32'h8000_0100);
    push(32'h8000_0104, 32'h8000_0100);
    adv();

    // Flush while the request is still outstanding
    go(0, 0, 1, 32'h8000_0200);
    chk("t4_addr_a", imem_addr, 32'h8000_0104);
    adv();
    go(0, 0, 0, 32'h0);
    chk("t4_drop_addr", imem_addr, 32'h8000_0104);
    chk("t4_drop_req", {31'd0, imem_req}, 32'd1);
    chk("t4_drop_valid", {31'd0, id_valid}, 32'd0);
    adv();
    go(1, 0, 0, 32'h0);
    chk("t4_drop_ack_addr", imem_addr, 32'h8000_0104);
    chk("t4_drop_ack_valid", {31'd0, id_valid}, 32'd0);
    adv();
    go(1, 0, 0, 32'h0);
    chk("t4_target_addr", imem_addr, 32'h8000_0200);
    chk("t4_target_valid", {31'd0, id_valid}, 32'd0);
    push(32'h8000_0204, 32'h8000_0200);
    adv();

    // Flush together with stall is ignored
    go(0, 1, 1, 32'h9000_0000);
    chk("t5_addr", imem_addr, 32'h8000_0204);
    adv();
    go(0, 1, 1, 32'h9000_0000);
    chk("t5_valid_held", {31'd0, id_valid}, 32'd1);
    chk("t5_pc4_held", id_pc4, 32'h8000_0204);
    chk("t5_addr_held", imem_addr, 32'h8000_0204);
    adv();
    go(1, 0, 1, 32'h9000_0000);
    chk("t5_addr_before", imem_addr, 32'h8000_0204);
    adv();

    // Wrap at top of address space, then asynchronous reset mid-request
    go(1, 0, 1, 32'hFFFF_FFFC);
    chk("t5_redir_addr", imem_addr, 32'h9000_0000);
    chk("t5_redir_valid", {31'd0, id_valid}, 32'd0);
    adv();
    go(1, 0, 0, 32'h0);
    chk("t6_top_addr", imem_addr, 32'hFFFF_FFFC);
    push(32'h0000_0000, 32'hFFFF_FFFC);
    adv();
    go(0, 0, 0, 32'h0);
    chk("t6_wrap_addr", imem_addr, 32'h0000_0000);
    adv();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_req", {31'd0, imem_req}, 32'd1);
    chk("t6_rst_addr", imem_addr, 32'hBFC0_0000);
    chk("t6_rst_valid", {31'd0, id_valid}, 32'd0);
    chk("t6_rst_instr", id_instr, 32'h0);
    chk("t6_rst_queue", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    go(1, 0, 0, 32'h0);
    chk("t6_refetch_addr", imem_addr, 32'hBFC0_0000);
    push(32'hBFC0_0004, 32'hBFC0_0000);
    adv();
    go(0, 0, 0, 32'h0);
    chk("t6_next_addr", imem_addr, 32'hBFC0_0004);
    adv();
    go(0, 0, 0, 32'h0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
